// File: rtl/breakout_pkg.sv
// Shared definitions for the breakout game path: state encoding used by the
// game controller, the graphics unit and the display mux.
package breakout_pkg;

  typedef logic [1:0] game_state_t;

  localparam game_state_t NEWGAME = 2'b00;
  localparam game_state_t PLAY    = 2'b01;
  localparam game_state_t NEWBALL = 2'b10;
  localparam game_state_t OVER    = 2'b11;

endpackage

// File: rtl/bcd_sat_counter.sv
// Packed-BCD up counter that sticks at all-9s instead of wrapping.
// Digit 0 sits in the LSBs; clr has priority over inc.
module bcd_sat_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  inc,
  output logic [4*DIGITS-1:0]   q
);

  logic [4*DIGITS-1:0] q_inc;
  logic                carry;
  logic                all_nines;

  // Ripple a decimal carry through the digits; hold the value once every digit is 9
  always_comb begin
    q_inc     = q;
    carry     = 1'b1;
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (q[4*i +: 4] != 4'd9) all_nines = 1'b0;
      if (carry) begin
        if (q[4*i +: 4] == 4'd9) begin
          q_inc[4*i +: 4] = 4'd0;
        end else begin
          q_inc[4*i +: 4] = q[4*i +: 4] + 4'd1;
          carry           = 1'b0;
        end
      end
    end
    if (all_nines) q_inc = q;
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (inc) begin
      q <= q_inc;
    end
  end

endmodule

// File: rtl/breakout_game_ctrl.sv
// Game-flow controller: newgame -> play -> newball/over, with lives, a BCD
// score, a hold-off timer after each miss and start rising-edge detection.
// Every output is registered, so an event shows up on the following cycle.
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int SCORE_DIGITS = 4,
  parameter int DELAY_CYCLES = 50_000_000,
  parameter int LW           = $clog2(LIVES + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      hit,
  input  logic                      miss,
  output game_state_t               state,
  output logic                      gra_still,
  output logic [4*SCORE_DIGITS-1:0] score,
  output logic [LW-1:0]             lives_left,
  output logic                      game_over,
  output logic                      hold_busy
);

  localparam int TW = $clog2(DELAY_CYCLES + 1);

  game_state_t   state_d;
  logic          start_d;
  logic          start_rise;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_d;
  logic [LW-1:0] lives_d;
  logic          score_clr;
  logic          score_inc;
  logic          gra_still_d;
  logic          game_over_d;

  // start_d resets to 1 so a start held through reset is not seen as an edge
  assign start_rise = start & ~start_d;

  // State register plus the registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= NEWGAME;
      start_d    <= 1'b1;
      timer      <= '0;
      lives_left <= LW'(LIVES);
      gra_still  <= 1'b1;
      game_over  <= 1'b0;
      hold_busy  <= 1'b0;
    end else begin
      state      <= state_d;
      start_d    <= start;
      timer      <= timer_d;
      lives_left <= lives_d;
      gra_still  <= gra_still_d;
      game_over  <= game_over_d;
      hold_busy  <= (timer_d != '0);
    end
  end

  // Next-state, timer, lives and score controls; hit/miss only matter in play
  always_comb begin
    state_d   = state;
    lives_d   = lives_left;
    score_clr = 1'b0;
    score_inc = 1'b0;
    // The timer only ever counts down toward zero and never wraps
    timer_d   = (timer != '0) ? timer - TW'(1) : timer;
    case (state)
      NEWGAME: begin
        if (start_rise) begin
          score_clr = 1'b1;
          lives_d   = LW'(LIVES);
          state_d   = PLAY;
        end
      end
      PLAY: begin
        score_inc = hit;
        if (miss) begin
          lives_d = lives_left - LW'(1);
          timer_d = TW'(DELAY_CYCLES);
          state_d = (lives_left > LW'(1)) ? NEWBALL : OVER;
        end
      end
      NEWBALL: begin
        // An early start press is dropped, not queued
        if (start_rise && timer == '0) state_d = PLAY;
      end
      default: begin
        if (timer == '0) state_d = NEWGAME;
      end
    endcase
  end

  // Output decode for the registered flags, taken from the upcoming state
  always_comb begin
    gra_still_d = (state_d != PLAY);
    game_over_d = (state_d == OVER);
  end

  bcd_sat_counter #(
    .DIGITS (SCORE_DIGITS)
  ) u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .q     (score)
  );

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Bench for breakout_game_ctrl: a hand-computed vector table, directed
// sequences for the multi-cycle corners, then random play against a model.
module tb_breakout_game_ctrl;

  localparam int LIVES        = 3;
  localparam int SCORE_DIGITS = 2;
  localparam int DELAY_CYCLES = 8;
  localparam int LW           = $clog2(LIVES + 1);
  localparam int MAX_SCORE    = 10**SCORE_DIGITS - 1;

  // ---------------- clock / reset / DUT ----------------
  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic                      start = 1'b1;
  logic                      hit = 1'b0;
  logic                      miss = 1'b0;
  logic [1:0]                state;
  logic                      gra_still;
  logic [4*SCORE_DIGITS-1:0] score;
  logic [LW-1:0]             lives_left;
  logic                      game_over;
  logic                      hold_busy;

  always #5 clk = ~clk;

  breakout_game_ctrl #(
    .LIVES        (LIVES),
    .SCORE_DIGITS (SCORE_DIGITS),
    .DELAY_CYCLES (DELAY_CYCLES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .hit        (hit),
    .miss       (miss),
    .state      (state),
    .gra_still  (gra_still),
    .score      (score),
    .lives_left (lives_left),
    .game_over  (game_over),
    .hold_busy  (hold_busy)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Game described with plain integers: mode 0 newgame, 1 play, 2 newball, 3 over.
  int m_mode    = 0;
  int m_score   = 0;
  int m_lives   = LIVES;
  int m_timer   = 0;
  bit m_start_d = 1'b1;

  function automatic logic [4*SCORE_DIGITS-1:0] to_bcd(input int v);
    logic [4*SCORE_DIGITS-1:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_step(input bit rst, input bit st, input bit h, input bit m);
    bit rise;
    int had;
    if (rst) begin
      m_mode = 0; m_score = 0; m_lives = LIVES; m_timer = 0; m_start_d = 1'b1;
      return;
    end
    rise = st && !m_start_d;
    m_start_d = st;
    case (m_mode)
      0: if (rise) begin
           m_score = 0; m_lives = LIVES; m_mode = 1;
         end
      1: begin
           if (h && m_score < MAX_SCORE) m_score = m_score + 1;
           if (m) begin
             had = m_lives;
             m_lives = m_lives - 1;
             m_timer = DELAY_CYCLES;
             m_mode = (had > 1) ? 2 : 3;
           end
         end
      2: begin
           if (m_timer == 0 && rise) m_mode = 1;
           else if (m_timer > 0) m_timer = m_timer - 1;
         end
      default: begin
           if (m_timer == 0) m_mode = 0;
           else m_timer = m_timer - 1;
         end
    endcase
  endtask

  task automatic check_model();
    check("state",      32'(state),      32'(m_mode));
    check("gra_still",  32'(gra_still),  32'(m_mode != 1));
    check("score",      32'(score),      32'(to_bcd(m_score)));
    check("lives_left", 32'(lives_left), 32'(m_lives));
    check("game_over",  32'(game_over),  32'(m_mode == 3));
    check("hold_busy",  32'(hold_busy),  32'(m_timer != 0));
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit rst, input bit st, input bit h, input bit m);
    reset = rst; start = st; hit = h; miss = m;
    @(posedge clk);
    #1;
    model_step(rst, st, h, m);
    check_model();
  endtask

  task automatic wait_timer();
    int n;
    n = 0;
    while (m_timer != 0 && n < 20) begin
      step(0, 0, 0, 0);
      n++;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit         rst, st, h, m;
    logic [1:0] e_state;
    logic [7:0] e_score;
    logic [1:0] e_lives;
    bit         e_hold;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // start held through reset, released, raised; then play and a miss with hit
    vecs[0]  = '{1, 1, 0, 0, 2'b00, 8'h00, 2'd3, 0};
    vecs[1]  = '{1, 1, 0, 0, 2'b00, 8'h00, 2'd3, 0};
    vecs[2]  = '{0, 1, 0, 0, 2'b00, 8'h00, 2'd3, 0};
    vecs[3]  = '{0, 0, 0, 0, 2'b00, 8'h00, 2'd3, 0};
    vecs[4]  = '{0, 1, 0, 0, 2'b01, 8'h00, 2'd3, 0};
    vecs[5]  = '{0, 0, 1, 0, 2'b01, 8'h01, 2'd3, 0};
    vecs[6]  = '{0, 0, 1, 0, 2'b01, 8'h02, 2'd3, 0};
    vecs[7]  = '{0, 0, 1, 1, 2'b10, 8'h03, 2'd2, 1};
    vecs[8]  = '{0, 0, 0, 0, 2'b10, 8'h03, 2'd2, 1};
    vecs[9]  = '{0, 1, 0, 0, 2'b10, 8'h03, 2'd2, 1};
    vecs[10] = '{0, 0, 0, 0, 2'b10, 8'h03, 2'd2, 1};
    vecs[11] = '{0, 0, 1, 0, 2'b10, 8'h03, 2'd2, 1};
    vecs[12] = '{0, 0, 0, 1, 2'b10, 8'h03, 2'd2, 1};

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, vecs[i].st, vecs[i].h, vecs[i].m);
      check($sformatf("vec%0d_state", i), 32'(state),      32'(vecs[i].e_state));
      check($sformatf("vec%0d_score", i), 32'(score),      32'(vecs[i].e_score));
      check($sformatf("vec%0d_lives", i), 32'(lives_left), 32'(vecs[i].e_lives));
      check($sformatf("vec%0d_hold", i),  32'(hold_busy),  32'(vecs[i].e_hold));
    end

    // Hold-off expires, then a start edge resumes play
    wait_timer();
    check("hold_done", 32'(hold_busy), 32'(0));
    step(0, 1, 0, 0);
    check("resume_play", 32'(state), 32'(2'b01));
    step(0, 0, 0, 0);

    // Score 03 -> 12 -> saturate at 99
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
    check("score_12", 32'(score), 32'(8'h12));
    for (int i = 0; i < 90; i++) step(0, 0, 1, 0);
    check("score_sat", 32'(score), 32'(8'h99));

    // Second and third miss -> over, then automatic return to newgame
    step(0, 0, 0, 1);
    check("lives_1", 32'(lives_left), 32'(1));
    wait_timer();
    step(0, 1, 0, 0);
    step(0, 0, 0, 1);
    check("over_state", 32'(state), 32'(2'b11));
    check("over_flag",  32'(game_over), 32'(1));
    check("over_lives", 32'(lives_left), 32'(0));
    for (int n = 0; n < 30 && m_mode == 3; n++) step(0, 0, 0, 0);
    check("auto_newgame", 32'(state), 32'(2'b00));
    check("score_kept",   32'(score), 32'(8'h99));

    // New game, reach score 05 / lives 2, then hit and miss together
    step(0, 1, 0, 0);
    check("newgame_score", 32'(score), 32'(8'h00));
    check("newgame_lives", 32'(lives_left), 32'(3));
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    wait_timer();
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    check("hm_score", 32'(score), 32'(8'h06));
    check("hm_lives", 32'(lives_left), 32'(1));
    check("hm_state", 32'(state), 32'(2'b10));

    // Reset in newball with the timer at 5
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_state", 32'(state), 32'(2'b00));
    check("rst_score", 32'(score), 32'(8'h00));
    check("rst_lives", 32'(lives_left), 32'(3));
    check("rst_hold",  32'(hold_busy), 32'(0));

    // Random play against the model
    begin
      bit st_r;
      st_r = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 3) == 0) st_r = ~st_r;
        step($urandom_range(0, 299) == 0, st_r,
             $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
